// File: rtl/lsu_pkg.sv
// Shared constants and FSM state type for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: enables and replicated store data from the request,
// lane extraction and extension of the returned read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    be       = 4'b1111;
    st_lanes = st_data;
    case (st_funct3)
      F3_B, F3_BU: begin
        be       = 4'b0001 << st_lo;
        st_lanes = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be       = 4'b0011 << st_lo;
        st_lanes = {2{st_data[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        st_lanes = st_data;
      end
    endcase
  end

  // The addressed byte/halfword is brought down to bit 0 before extension.
  always_comb begin
    shifted = rdata >> {ld_lo, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access at a time over a req/ack bus.
// Optional bus-ack timeout fault enabled by defining LSU_TIMEOUT_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Handshake: a request is taken on a clock edge where ex_valid && ex_ready
  // and a direction bit is set; bus_req holds until the edge sampling bus_ack.
  state_t      state;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        is_load, f3_bad, misalign;
  logic [3:0]  be_n;
  logic [31:0] lanes_n, load_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`else
  // Parameter has no effect while the timeout counter is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  lsu_align u_align (
    .st_funct3 (funct3),
    .st_lo     (addr[1:0]),
    .st_data   (wdata),
    .be        (be_n),
    .st_lanes  (lanes_n),
    .ld_funct3 (f3_q),
    .ld_lo     (lo_q),
    .rdata     (bus_rdata),
    .ld_data   (load_ext)
  );

  always_comb begin
    is_load  = mem_read;
    f3_bad   = 1'b0;
    misalign = 1'b0;
    case (funct3)
      F3_B:    f3_bad = 1'b0;
      F3_BU:   f3_bad = !is_load;
      F3_H:    misalign = addr[0];
      F3_HU: begin
        f3_bad   = !is_load;
        misalign = addr[0];
      end
      F3_W:    misalign = |addr[1:0];
      default: f3_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ex_ready  <= 1'b1;
      done      <= 1'b0;
      load_data <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      ld_q      <= 1'b0;
      f3_q      <= '0;
      lo_q      <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid && ex_ready && (mem_read || mem_write)) begin
            ex_ready <= 1'b0;
            ld_q     <= is_load;
            f3_q     <= funct3;
            lo_q     <= addr[1:0];
            if (f3_bad || misalign) begin
              state     <= RESP;
              done      <= 1'b1;
              err       <= 1'b1;
              err_code  <= f3_bad ? ERR_FUNCT3 : ERR_MISALIGN;
              load_data <= '0;
            end else begin
              state     <= BUS;
              bus_req   <= 1'b1;
              bus_we    <= !is_load;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_n;
              bus_wdata <= lanes_n;
`ifdef LSU_TIMEOUT_EN
              cnt       <= '0;
`endif
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            state     <= RESP;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            load_data <= ld_q ? load_ext : 32'h0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= RESP;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            load_data <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          state     <= IDLE;
          done      <= 1'b0;
          ex_ready  <= 1'b1;
          load_data <= '0;
          err       <= 1'b0;
          err_code  <= ERR_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vectors plus randomized accesses
// checked against a byte-arithmetic reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        ex_ready, done, err, bus_req, bus_we;
  logic [1:0]  err_code;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  localparam int TO = 16;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .done(done), .load_data(load_data),
    .err(err), .err_code(err_code), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access driven from IDLE; all expectations come from the model below.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input int k);
    logic        ld, bad_f3, mis;
    int          size, off;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld, mask;
    logic [1:0]  e_code;
    logic [39:0] e_iss;
    ld     = rd;
    size   = 1 << f3[1:0];
    off    = int'(a[1:0]);
    bad_f3 = (f3 == 3'd3) || (f3 >= 3'd6) || (f3[2] && !ld);
    mis    = !bad_f3 && ((off % size) != 0);
    e_be   = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % size) +: 8];
    mask   = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    e_ld   = (rword >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && e_ld[8*size-1]) e_ld = e_ld | ~mask;
    if (!ld) e_ld = 32'h0;
    exp_q.push_back(e_ld);

    ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    step();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; wdata = $urandom;

    if (bad_f3 || mis) begin
      e_code = bad_f3 ? 2'b10 : 2'b01;
      n_tests++;
      if ({done, err, err_code, bus_req, load_data} !== {1'b1, 1'b1, e_code, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL fault_resp f3=%0d addr=%h got done/err/code/req/data=%b%b%b%b %h exp 11%b0 0",
                 f3, a, done, err, err_code, bus_req, load_data, e_code);
      end
      void'(exp_q.pop_front());
    end else begin
      e_iss = {1'b1, !ld, a[31:2], 2'b00, e_be, 1'b0, 1'b0};
      for (int c = 0; c <= k; c++) begin
        n_tests++;
        if ({bus_req, bus_we, bus_addr, bus_be, ex_ready, done} !== e_iss) begin
          n_fail++;
          $display("FAIL bus_issue cyc=%0d addr=%h got=%h exp=%h", c, a,
                   {bus_req, bus_we, bus_addr, bus_be, ex_ready, done}, e_iss);
        end
        if (!ld) begin
          n_tests++;
          if (bus_wdata !== e_wd) begin
            n_fail++;
            $display("FAIL bus_wdata cyc=%0d got=%h exp=%h", c, bus_wdata, e_wd);
          end
        end
        if (c < k) step();
      end
      bus_ack = 1'b1; bus_rdata = rword;
      step();
      bus_ack = 1'b0; bus_rdata = $urandom;
      e_ld = exp_q.pop_front();
      n_tests++;
      if ({done, err, err_code, bus_req, load_data} !== {1'b1, 1'b0, 2'b00, 1'b0, e_ld}) begin
        n_fail++;
        $display("FAIL done_resp f3=%0d addr=%h got done/err/code/req=%b%b%b%b data=%h exp 1000 data=%h",
                 f3, a, done, err, err_code, bus_req, load_data, e_ld);
      end
    end
    step();
    n_tests++;
    if ({done, ex_ready, err, bus_req} !== 4'b0100) begin
      n_fail++;
      $display("FAIL resp_one_cycle got done/ready/err/req=%b exp 0100", {done, ex_ready, err, bus_req});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_tests++;
    if ({ex_ready, done, load_data, err, err_code, bus_req, bus_we, bus_addr, bus_be, bus_wdata}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state ready=%b done=%b req=%b addr=%h be=%b exp ready=1 rest 0",
               ex_ready, done, bus_req, bus_addr, bus_be);
    end
  endtask

  task automatic test_plan_vectors();
    do_access(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
    do_access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0);
    do_access(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 1);
    do_access(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0);
    do_access(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0);
    do_access(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0);
    do_access(0, 1, 3'b101, 32'h0000_0100, 32'h0, 32'h0, 0);
    do_access(1, 1, 3'b101, 32'h0000_0042, 32'h0, 32'h9876_5432, 2);
  endtask

  task automatic test_ack_delay();
    do_access(1, 0, 3'b010, 32'h0000_0400, 32'h0, 32'h1234_5678, 5);
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
    step();
    ex_valid = 1'b0; mem_read = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if ({bus_req, done, ex_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_mid got req/done/ready=%b exp 001", {bus_req, done, ex_ready});
    end
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_ack = 1'b0;
    step();
    n_tests++;
    if ({bus_req, done, ex_ready, err} !== 4'b0010) begin
      n_fail++;
      $display("FAIL late_ack got req/done/ready/err=%b exp 0010", {bus_req, done, ex_ready, err});
    end
  endtask

  task automatic test_ignored();
    ex_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h10;
    bus_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if ({done, ex_ready, bus_req} !== 3'b010) begin
        n_fail++;
        $display("FAIL ignored_req cyc=%0d got done/ready/req=%b exp 010", c, {done, ex_ready, bus_req});
      end
    end
    ex_valid = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_access(1, 0, 3'b001, 32'h0000_0013, 32'h0, 32'h0, 0);
    do_access(0, 1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0, 0);
    do_access(1, 0, 3'b001, 32'h0000_0012, 32'h0, 32'hF00F_1234, 0);
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                $urandom_range(0, 4));
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    for (int w = 0; w < 2; w++) begin
      ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0800;
      step();
      ex_valid = 1'b0; mem_read = 1'b0;
      for (int c = 0; c < TO; c++) begin
        n_tests++;
        if ({bus_req, done} !== 2'b10) begin
          n_fail++;
          $display("FAIL timeout_wait cyc=%0d got req/done=%b exp 10", c, {bus_req, done});
        end
        if (w == 1 && c == TO - 1) begin
          bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        end
        step();
        bus_ack = 1'b0;
      end
      n_tests++;
      if (w == 0 && {done, err, err_code, bus_req} !== 5'b11110) begin
        n_fail++;
        $display("FAIL timeout_resp got done/err/code/req=%b exp 11110", {done, err, err_code, bus_req});
      end else if (w == 1 && {done, err, err_code, bus_req, load_data} !== {5'b10000, 32'h5555_AAAA}) begin
        n_fail++;
        $display("FAIL ack_wins got done/err/code/req=%b data=%h exp 10000 5555aaaa",
                 {done, err, err_code, bus_req}, load_data);
      end
      step();
    end
  endtask
`else
  task automatic test_long_wait();
    do_access(1, 0, 3'b000, 32'h0000_0901, 32'h0, 32'h0000_7F00, 40);
  endtask
`endif

  initial begin
    test_reset();
    test_plan_vectors();
    test_ack_delay();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
